mnk_game_core: RTL

- Parametrised successor to the fixed 3x3 tic-tac-toe controller: a generalised m,n,k game engine on an N x N board with K-in-a-row win.
- Holds the board, validates and applies player moves, and alternates turns.
- Replaces the combinational win logic with a sequential scanner that checks only the lines through the last placed cell, so area stays flat as N grows.
- Sits under the chip top in place of the controller / memory array / win logic trio.

---
 rtl/mnk_game_core_pkg.sv | 29 ++
 rtl/mnk_game_core_if.sv | 23 ++
 rtl/mnk_game_core_line_scanner.sv | 76 +++++++
 rtl/mnk_game_core.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mnk_game_core_pkg.sv
// Shared types for the m,n,k game engine: cell codes, results, turn states,
// and the row/col step of each scan direction.
package mnk_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P2    = 2'b10,
    P1    = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    NOWIN = 2'b00,
    TIE   = 2'b01,
    P2WIN = 2'b10,
    P1WIN = 2'b11
  } result_t;

  typedef enum logic [2:0] {
    P1_TURN = 3'b001,
    P2_TURN = 3'b010,
    CHECK   = 3'b011,
    DONE    = 3'b100
  } state_t;

  // Scan order: horizontal, vertical, diagonal, anti-diagonal.
  localparam logic signed [7:0] DIR_DR [4] = '{8'sd0, 8'sd1, 8'sd1,  8'sd1};
  localparam logic signed [7:0] DIR_DC [4] = '{8'sd1, 8'sd0, 8'sd1, -8'sd1};

endpackage

// File: rtl/mnk_game_core_if.sv
// Move handshake and game status bundle for mnk_game_core.
interface mnk_game_core_if #(parameter int N = 3);
  localparam int ADDR_W = $clog2(N*N);

  logic              playerWrite;
  logic [ADDR_W-1:0] playerInput;
  logic              moveAccept;
  logic              moveReject;
  logic              busy;
  logic [2*N*N-1:0]  gBoard;
  logic [2:0]        gameState;
  logic [1:0]        winner;

  modport master (
    output playerWrite, playerInput,
    input  moveAccept, moveReject, busy, gBoard, gameState, winner
  );

  modport slave (
    input  playerWrite, playerInput,
    output moveAccept, moveReject, busy, gBoard, gameState, winner
  );
endinterface

// File: rtl/mnk_game_core_line_scanner.sv
// Sequential K-in-a-row detector: walks the four lines through the last
// placed cell, one neighbour per cycle, both sides per line.
module mnk_line_scanner
  import mnk_pkg::*;
#(
  parameter  int N      = 3,
  parameter  int K      = 3,
  localparam int ADDR_W = $clog2(N*N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_last_cell,
  input  cell_t             i_cur_player,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  cell_t             i_rd_data,
  output logic              o_done,
  output logic              o_won
);

  logic             r_active;
  logic [1:0]       r_dir;
  logic             r_side;
  logic [3:0]       r_step;
  logic [3:0]       r_count;

  logic signed [7:0] w_row, w_col, w_off, w_nr, w_nc;
  logic              w_inb, w_match, w_hit_k, w_adv;

  // Neighbour address for the current direction/side/step and its evaluation.
  always_comb begin
    w_row     = 8'(i_last_cell / ADDR_W'(N));
    w_col     = 8'(i_last_cell % ADDR_W'(N));
    w_off     = r_side ? -$signed({4'b0, r_step}) : $signed({4'b0, r_step});
    w_nr      = w_row + w_off * DIR_DR[r_dir];
    w_nc      = w_col + w_off * DIR_DC[r_dir];
    w_inb     = (w_nr >= 8'sd0) && (w_nr < 8'(N)) && (w_nc >= 8'sd0) && (w_nc < 8'(N));
    o_rd_addr = w_inb ? ADDR_W'(w_nr * 8'(N) + w_nc) : '0;
    w_match   = r_active && w_inb && (i_rd_data == i_cur_player);
    w_hit_k   = w_match && ((r_count + 4'd1) == 4'(K));
    // A side ends on edge/mismatch, or after its K-1th matching step.
    w_adv     = r_active && !w_hit_k && (!w_match || (r_step == 4'(K-1)));
    o_done    = w_hit_k || (w_adv && r_side && (r_dir == 2'd3));
    o_won     = w_hit_k;
  end

  // Scan position and run-length registers.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) begin
      r_active <= i_start && !i_rst;
      r_dir    <= '0;
      r_side   <= 1'b0;
      r_step   <= 4'd1;
      r_count  <= 4'd1;
    end else if (r_active) begin
      if (o_done) begin
        r_active <= 1'b0;
      end else begin
        if (w_match) r_count <= r_count + 4'd1;
        if (w_adv) begin
          r_step <= 4'd1;
          if (!r_side) begin
            r_side <= 1'b1;
          end else begin
            r_side  <= 1'b0;
            r_dir   <= r_dir + 2'd1;
            r_count <= 4'd1;
          end
        end else if (w_match) begin
          r_step <= r_step + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mnk_game_core.sv
// m,n,k game engine: N x N board, K-in-a-row win, alternating turns.
// Optional REMATCH_EN: a playerWrite in DONE starts a new game with the
// other player opening; otherwise DONE holds until reset.
module mnk_game_core
  import mnk_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input logic           ph1,
  input logic           reset,
  input logic           isPlayer1Start,
  mnk_game_core_if.slave bus
);

  localparam int ADDR_W = $clog2(N*N);
  localparam int MW     = $clog2(N*N+1);

  cell_t             r_cells [N*N];
  state_t            r_state;
  result_t           r_winner;
  logic              r_accept, r_reject;
  logic [MW-1:0]     r_moves;
  logic [ADDR_W-1:0] r_last_cell;
  cell_t             r_cur_player;
`ifdef REMATCH_EN
  cell_t             r_starter;
`endif

  state_t            w_state_n;
  result_t           w_winner_n;
  logic              w_in_range, w_turn, w_free, w_accept, w_reject, w_clear;
  logic [ADDR_W-1:0] w_idx, w_rd_addr;
  cell_t             w_player, w_rd_data;
  logic              w_scan_done, w_scan_won;

  assign w_rd_data     = r_cells[w_rd_addr];
  assign bus.moveAccept = r_accept;
  assign bus.moveReject = r_reject;
  assign bus.busy       = (r_state == CHECK);
  assign bus.gameState  = r_state;
  assign bus.winner     = r_winner;

  for (genvar g = 0; g < N*N; g++) begin : g_board
    assign bus.gBoard[2*g +: 2] = r_cells[g];
  end

  mnk_line_scanner #(.N(N), .K(K)) u_scan (
    .i_clk        (ph1),
    .i_rst        (reset),
    .i_start      (w_accept),
    .i_last_cell  (r_last_cell),
    .i_cur_player (r_cur_player),
    .o_rd_addr    (w_rd_addr),
    .i_rd_data    (w_rd_data),
    .o_done       (w_scan_done),
    .o_won        (w_scan_won)
  );

  // Move validation and next turn/result decision.
  always_comb begin
    w_in_range = ({1'b0, bus.playerInput} < (ADDR_W+1)'(N*N));
    w_idx      = w_in_range ? bus.playerInput : '0;
    w_turn     = (r_state == P1_TURN) || (r_state == P2_TURN);
    w_player   = (r_state == P1_TURN) ? P1 : P2;
    w_free     = w_in_range && (r_cells[w_idx] == EMPTY);
    w_accept   = w_turn && bus.playerWrite && w_free;
    w_reject   = w_turn && bus.playerWrite && !w_free;
    w_clear    = 1'b0;
    w_state_n  = r_state;
    w_winner_n = r_winner;
    case (r_state)
      P1_TURN, P2_TURN: if (w_accept) w_state_n = CHECK;
      CHECK: begin
        if (w_scan_done) begin
          if (w_scan_won) begin
            w_state_n  = DONE;
            w_winner_n = (r_cur_player == P1) ? P1WIN : P2WIN;
          end else if (r_moves == MW'(N*N)) begin
            w_state_n  = DONE;
            w_winner_n = TIE;
          end else begin
            w_state_n = (r_cur_player == P1) ? P2_TURN : P1_TURN;
          end
        end
      end
      DONE: begin
`ifdef REMATCH_EN
        if (bus.playerWrite) begin
          w_clear    = 1'b1;
          w_winner_n = NOWIN;
          w_state_n  = (r_starter == P1) ? P2_TURN : P1_TURN;
        end
`endif
      end
      default: w_state_n = r_state;
    endcase
  end

  // Board, turn state, move counter and response pulses.
  always_ff @(posedge ph1) begin
    if (reset) begin
      for (int unsigned i = 0; i < N*N; i++) r_cells[i] <= EMPTY;
      r_state      <= isPlayer1Start ? P1_TURN : P2_TURN;
      r_winner     <= NOWIN;
      r_accept     <= 1'b0;
      r_reject     <= 1'b0;
      r_moves      <= '0;
      r_last_cell  <= '0;
      r_cur_player <= EMPTY;
`ifdef REMATCH_EN
      r_starter    <= isPlayer1Start ? P1 : P2;
`endif
    end else begin
      r_state  <= w_state_n;
      r_winner <= w_winner_n;
      r_accept <= w_accept;
      r_reject <= w_reject;
      if (w_accept) begin
        r_cells[w_idx] <= w_player;
        r_last_cell    <= w_idx;
        r_cur_player   <= w_player;
        r_moves        <= r_moves + 1'b1;
      end
      if (w_clear) begin
        for (int unsigned i = 0; i < N*N; i++) r_cells[i] <= EMPTY;
        r_moves <= '0;
`ifdef REMATCH_EN
        r_starter <= (r_starter == P1) ? P2 : P1;
`endif
      end
    end
  end

endmodule
